// File: rtl/stage_sequencer.sv
// Single-clock phase sequencer for the shrv32 core: one-cycle stage enables,
// shared memory port handshake, halt, retired-instruction count, timeout fault.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 halt,
    input  logic                 rwmem,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_is_fetch,
    output logic                 en_FT,
    output logic                 en_DC,
    output logic                 en_EX,
    output logic                 en_MA,
    output logic                 en_WB,
    output logic [2:0]           stage,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        START     = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXEC      = 3'd3,
        MEMACC    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        FAULT     = 3'd7
    } state_t;

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= START;
            wait_cnt <= 8'd0;
            instret  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == WRITEBACK)
                instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_is_fetch = 1'b0;
        en_FT        = 1'b0;
        en_DC        = 1'b0;
        en_EX        = 1'b0;
        en_MA        = 1'b0;
        en_WB        = 1'b0;
        halted       = 1'b0;
        timeout_err  = 1'b0;
        unique case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ack) begin
                    en_FT     = 1'b1;
                    state_nxt = DECODE;
                end else if (wait_cnt == LIMIT) begin
                    state_nxt = FAULT;
                end
            end
            DECODE: begin
                en_DC     = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                en_EX     = 1'b1;
                state_nxt = rwmem ? MEMACC : WRITEBACK;
            end
            MEMACC: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    en_MA     = 1'b1;
                    state_nxt = WRITEBACK;
                end else if (wait_cnt == LIMIT) begin
                    state_nxt = FAULT;
                end
            end
            WRITEBACK: begin
                en_WB     = 1'b1;
                state_nxt = halt ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt)
                    state_nxt = FETCH;
            end
            FAULT: timeout_err = 1'b1;
        endcase
    end

    // Counter restarts on every state change; it only advances while a
    // memory request is still waiting for its ack.
    always_comb begin
        wait_nxt = wait_cnt;
        if (state_nxt != state)
            wait_nxt = 8'd0;
        else if (mem_req)
            wait_nxt = wait_cnt + 8'd1;
    end

    assign stage = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-instruction schedules expanded into
// expected per-cycle outputs, directed scenarios plus random episodes.
module tb_stage_sequencer;

    localparam int TO = 4;
    localparam int IW = 6;

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEMACC = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic halt = 1'b0;
    logic rwmem = 1'b0;
    logic mem_ack = 1'b0;
    logic mem_req, mem_is_fetch;
    logic en_FT, en_DC, en_EX, en_MA, en_WB;
    logic [2:0] stage;
    logic halted, timeout_err;
    logic [IW-1:0] instret;

    stage_sequencer #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
        .CLK(CLK), .RST(RST), .halt(halt), .rwmem(rwmem),
        .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_is_fetch(mem_is_fetch),
        .en_FT(en_FT), .en_DC(en_DC), .en_EX(en_EX),
        .en_MA(en_MA), .en_WB(en_WB), .stage(stage),
        .halted(halted), .timeout_err(timeout_err),
        .instret(instret)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        halt;
        logic        rwmem;
        logic        ack;
        logic [17:0] exp;
    } cyc_t;

    cyc_t          sched[$];
    cyc_t          cur;
    bit            cur_valid = 1'b0;
    logic [IW-1:0] cnt;
    bit            faulted;
    int n_cmp = 0;
    int n_fail = 0;
    int c_ft, c_ma, c_wb, c_req, c_hlt, c_cyc;

    logic [17:0] dut_vec;
    assign dut_vec = {stage, mem_req, mem_is_fetch, en_FT, en_DC,
                      en_EX, en_MA, en_WB, halted, timeout_err, instret};

    function automatic logic rb();
        return 1'($urandom & 1);
    endfunction

    function automatic void push(logic [2:0] st, logic req, logic isf,
                                 logic [4:0] en, logic hl, logic er,
                                 logic h, logic r, logic a);
        cyc_t c;
        c.halt  = h;
        c.rwmem = r;
        c.ack   = a;
        c.exp   = {st, req, isf, en, hl, er, cnt};
        sched.push_back(c);
    endfunction

    // d = ack delay in cycles; anything beyond TO never gets acked.
    function automatic void mem_phase(logic [2:0] st, logic isf,
                                      logic [4:0] en, int d);
        int n;
        n = (d > TO) ? TO + 1 : d;
        for (int i = 0; i < n; i++)
            push(st, 1'b1, isf, 5'd0, 1'b0, 1'b0, rb(), rb(), 1'b0);
        if (d > TO) begin
            faulted = 1'b1;
            for (int i = 0; i < 3; i++)
                push(S_FAULT, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, rb(), rb(), rb());
        end else begin
            push(st, 1'b1, isf, en, 1'b0, 1'b0, rb(), rb(), 1'b1);
        end
    endfunction

    function automatic void instr(int df, bit r, int dm, int h);
        if (faulted) return;
        mem_phase(S_FETCH, 1'b1, 5'b10000, df);
        if (faulted) return;
        push(S_DECODE, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, rb(), rb(), rb());
        push(S_EXEC, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, rb(), r, rb());
        if (r) begin
            mem_phase(S_MEMACC, 1'b0, 5'b00010, dm);
            if (faulted) return;
        end
        push(S_WB, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, h > 0, rb(), rb());
        cnt++;
        for (int i = 0; i < h; i++)
            push(S_HALT, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, i < h - 1, rb(), rb());
    endfunction

    function automatic void start_ep();
        sched.delete();
        cnt = '0;
        faulted = 1'b0;
        push(S_START, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rb(), rb(), rb());
    endfunction

    task automatic check(string nm, logic [17:0] act, logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cur_valid) begin
            check("cycle", dut_vec, cur.exp);
            c_cyc++;
            c_ft  += int'(en_FT);
            c_ma  += int'(en_MA);
            c_wb  += int'(en_WB);
            c_req += int'(mem_req);
            c_hlt += int'(halted);
        end
    end

    task automatic clr_counts();
        c_ft = 0; c_ma = 0; c_wb = 0;
        c_req = 0; c_hlt = 0; c_cyc = 0;
    endtask

    task automatic do_reset();
        cur_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("reset", dut_vec, 18'd0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
    endtask

    task automatic run();
        while (sched.size() > 0) begin
            cur = sched.pop_front();
            halt = cur.halt;
            rwmem = cur.rwmem;
            mem_ack = cur.ack;
            cur_valid = 1'b1;
            @(negedge CLK);
            @(posedge CLK);
            #1;
        end
        cur_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        start_ep();
        for (int i = 0; i < 10; i++) instr(0, 1'b0, 0, 0);
        clr_counts();
        run();
        check_int("s1_cycles", c_cyc, 41);
        check_int("s1_instret", int'(instret), 10);
        check_int("s1_ft", c_ft, 10);
        check_int("s1_wb", c_wb, 10);
        check_int("s1_ma", c_ma, 0);
        do_reset();

        start_ep();
        for (int i = 0; i < 5; i++) instr(0, 1'b1, 0, 0);
        clr_counts();
        run();
        check_int("s2_cycles", c_cyc, 26);
        check_int("s2_ma", c_ma, 5);
        check_int("s2_instret", int'(instret), 5);
        do_reset();

        start_ep();
        instr(3, 1'b0, 0, 0);
        clr_counts();
        run();
        check_int("s3_cycles", c_cyc, 8);
        check_int("s3_req", c_req, 4);
        check_int("s3_ft", c_ft, 1);
        do_reset();

        start_ep();
        instr(5, 1'b0, 0, 0);
        clr_counts();
        run();
        check_int("s4_req", c_req, 5);
        check_int("s4_err", int'(timeout_err), 1);
        check_int("s4_memreq", int'(mem_req), 0);
        do_reset();

        start_ep();
        instr(4, 1'b0, 0, 0);
        run();
        check_int("s4b_err", int'(timeout_err), 0);
        check_int("s4b_instret", int'(instret), 1);
        do_reset();

        start_ep();
        instr(0, 1'b0, 0, 0);
        instr(0, 1'b0, 0, 3);
        clr_counts();
        run();
        check_int("s5_halted_cycles", c_hlt, 3);
        check_int("s5_req", c_req, 2);
        check_int("s5_instret", int'(instret), 2);
        check_int("s5_refetch", int'(stage), int'(S_FETCH));
        do_reset();

        start_ep();
        instr(0, 1'b0, 0, 0);
        instr(0, 1'b1, 3, 0);
        while (!(sched[$].exp[17:15] == S_MEMACC && sched[$].ack == 1'b0))
            void'(sched.pop_back());
        run();
        check_int("s6_req_before", int'(mem_req), 1);
        check_int("s6_instret_before", int'(instret), 1);
        do_reset();
        start_ep();
        instr(0, 1'b0, 0, 0);
        run();
        do_reset();

        for (int e = 0; e < 12; e++) begin
            int n;
            start_ep();
            n = int'($urandom_range(20, 90));
            for (int i = 0; i < n; i++) begin
                int r1, r2, df, dm, h;
                r1 = int'($urandom % 100);
                r2 = int'($urandom % 100);
                df = r1 < 60 ? 0 : (r1 < 98 ? int'($urandom_range(1, 4)) : 5);
                dm = r2 < 60 ? 0 : (r2 < 98 ? int'($urandom_range(1, 4)) : 5);
                h  = ($urandom % 100) < 15 ? int'($urandom_range(1, 3)) : 0;
                instr(df, 1'($urandom & 1), dm, h);
            end
            run();
            do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Single-clock replacement for the multi-phase stage clock generator in the shrv32 core. Sequences the five pipeline phases (fetch, decode, execute, memory access, write-back) with one-cycle stage-enable pulses instead of derived clocks. Owns the shared memory port request/acknowledge handshake for instruction fetch and data access. Adds a halt input, a retired-instruction counter and a sticky memory-timeout fault.

## Interface

Parameters:
- MEM_TIMEOUT, 255: wait cycles without mem_ack before fault; legal range 1..255.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- CLK  input  1  sole clock; all state updates on posedge.
- RST  input  1  reset, asynchronous, active-high.
- halt  input  1  request to stop after the current instruction retires.
- rwmem  input  1  current instruction needs the MA phase; sampled only in EXEC.
- mem_ack  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request pending; held until mem_ack.
- mem_is_fetch  output  1  1 = pending request is an instruction fetch, 0 = data access.
- en_FT, en_DC, en_EX, en_MA, en_WB  output  1 each  single-cycle stage enables.
- stage  output  3  current state encoding (debug).
- halted  output  1  sequencer parked in HALT.
- timeout_err  output  1  sticky memory-timeout fault.
- instret  output  INSTRET_W  retired instruction count.

## Operation

- States and encodings: START=0, FETCH=1, DECODE=2, EXEC=3, MEMACC=4, WRITEBACK=5, HALT=6, FAULT=7.
- START: leave reset; go to FETCH next cycle. No outputs asserted.
- FETCH: mem_req=1, mem_is_fetch=1. On mem_ack, en_FT=1 that cycle, go to DECODE. Without mem_ack, increment wait counter.
- DECODE: en_DC=1 for one cycle; go to EXEC.
- EXEC: en_EX=1 for one cycle. If rwmem=1 go to MEMACC, else go to WRITEBACK. MA phase is skipped entirely when rwmem=0.
- MEMACC: mem_req=1, mem_is_fetch=0. On mem_ack, en_MA=1 that cycle, go to WRITEBACK. Without mem_ack, increment wait counter.
- WRITEBACK: en_WB=1 for one cycle; instret increments by 1, wrapping modulo 2^INSTRET_W. If halt=1 go to HALT, else go to FETCH.
- HALT: halted=1, all enables 0, mem_req=0. Return to FETCH the cycle after halt is sampled 0.
- Wait counter: 8 bits, cleared on every state entry. When the counter equals MEM_TIMEOUT in FETCH or MEMACC and mem_ack=0, go to FAULT. If mem_ack arrives in the same cycle as the limit, the ack wins and there is no fault.
- FAULT: timeout_err=1, mem_req=0, all enables 0. Exit only through RST.
- mem_is_fetch is 0 whenever mem_req=0.
- mem_ack outside FETCH or MEMACC is ignored.
- At most one en_* signal is high in any cycle.

## Timing

- Reset values, applied asynchronously: state=START, mem_req=0, mem_is_fetch=0, all en_*=0, halted=0, timeout_err=0, instret=0, wait counter=0.
- Reset asserted mid-operation, including while mem_req is high, drops mem_req and all enables immediately. No retire is counted.
- Stage outputs are Moore-decoded from state. Exceptions: en_FT and en_MA, which are state AND mem_ack.
- First mem_req appears 1 cycle after RST deasserts, from START.
- With zero-wait memory (mem_ack in the first request cycle), an instruction takes:
  - rwmem=0: 4 cycles (FETCH, DECODE, EXEC, WRITEBACK).
  - rwmem=1: 5 cycles.
- Each cycle of mem_ack delay adds 1 cycle.
- halt affects only the WRITEBACK→next transition. Minimum halt response is 0 extra cycles when halt is high during WRITEBACK.
- Fault is entered in the cycle after the counter reaches MEM_TIMEOUT. With mem_ack held 0, the cycles spent in FETCH/MEMACC before FAULT = MEM_TIMEOUT+1.

## Test plan

- Reset then mem_ack tied 1, rwmem=0:
  - en_FT, en_DC, en_EX, en_WB each pulse once per 4 cycles, in order.
  - en_MA never pulses.
  - instret=10 after 40 cycles from the first FETCH.
- mem_ack tied 1, rwmem=1: 5-cycle period, and en_MA pulses in cycle 4 with mem_is_fetch=0.
- Fetch ack delayed 3 cycles: mem_req stays high 4 cycles with mem_is_fetch=1, en_FT pulses only on the ack cycle, and the instruction takes 7 cycles.
- MEM_TIMEOUT=4, mem_ack held 0:
  - FAULT is entered after 5 FETCH cycles; timeout_err=1 and mem_req=0 from then on.
  - A repeat run with mem_ack on the 5th cycle gives no fault.
- halt=1 during WRITEBACK of instruction 2:
  - halted=1, instret=2, no mem_req while halted.
  - Deasserting halt gives FETCH on the next cycle.
- RST pulsed while in MEMACC with mem_req=1: all outputs return to reset values in the same cycle, instret=0, and the first mem_req appears 1 cycle after release.
